// File: rtl/gen_habilita_pkg.sv
// gen_habilita_pkg: state encoding and synchronizer depth shared by gen_habilita
package gen_habilita_pkg;
  typedef enum logic {PARADO = 1'b0, CORRIENDO = 1'b1} estado_t;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/gen_habilita_if.sv
// gen_habilita_if: button, divisor and enable signals of gen_habilita
// master: drives Arranque/Parada/[Paso]/Divisor, reads E/Activo; slave: the converse
// Paso exists only when GEN_HABILITA_PASO_EN is defined
interface gen_habilita_if #(parameter int DIV_W = 16);
  logic Arranque;
  logic Parada;
`ifdef GEN_HABILITA_PASO_EN
  logic Paso;
`endif
  logic [DIV_W-1:0] Divisor;
  logic E;
  logic Activo;
`ifdef GEN_HABILITA_PASO_EN
  modport master(output Arranque, Parada, Paso, Divisor, input E, Activo);
  modport slave(input Arranque, Parada, Paso, Divisor, output E, Activo);
`else
  modport master(output Arranque, Parada, Divisor, input E, Activo);
  modport slave(input Arranque, Parada, Divisor, output E, Activo);
`endif
endinterface

// File: rtl/gen_habilita_sincronizador.sv
// sincronizador: 2-FF synchronizer plus rising-edge detector, one pulse per press
// CK clock, R async active-high reset, d async level in, pulso one-cycle event out
module sincronizador
  import gen_habilita_pkg::*;
(
  input  logic CK,
  input  logic R,
  input  logic d,
  output logic pulso
);
  logic [SYNC_DEPTH-1:0] s;
  logic prev;
  always_ff @(posedge CK or posedge R)
    if (R) begin
      s <= '0;
      prev <= 1'b0;
    end else begin
      s <= {s[SYNC_DEPTH-2:0], d};
      prev <= s[SYNC_DEPTH-1];
    end
  assign pulso = s[SYNC_DEPTH-1] & ~prev;
endmodule

// File: rtl/gen_habilita.sv
// gen_habilita: run/stop FSM with prescaler producing a one-cycle enable pulse E
// CK clock, R async active-high reset, b (slave): Arranque/Parada/[Paso] buttons,
// Divisor (E period = Divisor+1), E enable pulse, Activo high while running
// GEN_HABILITA_PASO_EN adds the Paso single-step button
module gen_habilita
  import gen_habilita_pkg::*;
#(parameter int DIV_W = 16)
(
  input logic CK,
  input logic R,
  gen_habilita_if.slave b
);
  estado_t estado, estado_n;
  logic ev_arr, ev_par, ev_paso, fin, e_q, e_n;
  logic [DIV_W-1:0] pre, pre_n;
  sincronizador u_arr (.CK(CK), .R(R), .d(b.Arranque), .pulso(ev_arr));
  sincronizador u_par (.CK(CK), .R(R), .d(b.Parada), .pulso(ev_par));
`ifdef GEN_HABILITA_PASO_EN
  sincronizador u_paso (.CK(CK), .R(R), .d(b.Paso), .pulso(ev_paso));
`else
  assign ev_paso = 1'b0;
`endif
  // >= rather than == so a Divisor lowered below pre yields one pulse, not a wrap
  assign fin = pre >= b.Divisor;
  always_comb begin
    estado_n = ev_par ? PARADO : (ev_arr ? CORRIENDO : estado);
    pre_n = (estado == CORRIENDO && !fin) ? pre + 1'b1 : '0;
    e_n = (estado == CORRIENDO) ? fin : ev_paso;
  end
  always_ff @(posedge CK or posedge R)
    if (R) begin
      estado <= PARADO;
      pre <= '0;
      e_q <= 1'b0;
    end else begin
      estado <= estado_n;
      pre <= pre_n;
      e_q <= e_n;
    end
  assign b.E = e_q;
  assign b.Activo = estado == CORRIENDO;
endmodule
